// File: rtl/speed_actuator_if.sv
// Speed actuator handshake bundle: driving-control requests in,
// modelled speed and door latch state out.
interface speed_actuator_if;
  logic       accelerate_car;
  logic       unlock_doors;
  logic       brake_override;
  logic [7:0] car_speed;
  logic       speed_valid;
  logic       moving;
  logic       door_unlocked;

  // Driving-control side: issues requests, observes speed/doors
  modport master (
    output accelerate_car,
    output unlock_doors,
    output brake_override,
    input  car_speed,
    input  speed_valid,
    input  moving,
    input  door_unlocked
  );

  // Actuator side: consumes requests, reports speed/doors
  modport slave (
    input  accelerate_car,
    input  unlock_doors,
    input  brake_override,
    output car_speed,
    output speed_valid,
    output moving,
    output door_unlocked
  );
endinterface

// File: rtl/speed_actuator.sv
// Speed actuator: tick-paced speed model with accel/decel FSM,
// emergency brake and a parked-time door interlock.
module speed_actuator #(
  parameter int         TICK_DIV  = 4,
  parameter logic [7:0] ACC_STEP  = 8'd2,
  parameter logic [7:0] DEC_STEP  = 8'd3,
  parameter logic [7:0] MAX_SPEED = 8'd200,
  parameter int         DOOR_HOLD = 3
) (
  input  logic              clk,
  input  logic              rst,
  speed_actuator_if.slave   bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (DOOR_HOLD > 0) ? $clog2(DOOR_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    PARKED = 2'b00,
    ACCEL  = 2'b01,
    DECEL  = 2'b10
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [PW-1:0] r_park_cnt;
  logic [7:0]    r_speed;
  logic          r_valid;
  logic          r_door;

  logic          w_tick;
  logic          w_go;
  logic [8:0]    w_sum;
  logic [7:0]    w_acc_speed;
  logic [8:0]    w_dstep;
  logic [7:0]    w_dec_speed;
  logic          w_door_clr;
  logic          w_door_set;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_go   = bus.accelerate_car & ~bus.brake_override;

  // Next-speed candidates: saturating add, floored subtract
  always_comb begin
    w_sum       = {1'b0, r_speed} + {1'b0, ACC_STEP};
    w_acc_speed = (w_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED
                                              : w_sum[7:0];
    w_dstep     = bus.brake_override ? {DEC_STEP, 1'b0}
                                     : {1'b0, DEC_STEP};
    w_dec_speed = 8'd0;
    if ({1'b0, r_speed} > w_dstep)
      w_dec_speed = r_speed - w_dstep[7:0];
  end

  // Door latch: clear wins; set needs a long enough parked spell
  always_comb begin
    w_door_clr = ~bus.unlock_doors
               | bus.accelerate_car
               | (r_state != PARKED);
    w_door_set = (r_state == PARKED)
               & bus.unlock_doors
               & (r_park_cnt == PW'(DOOR_HOLD));
  end

  // Free-running tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Drive FSM with registered speed, update pulse, park count, doors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PARKED;
      r_speed    <= 8'd0;
      r_valid    <= 1'b0;
      r_park_cnt <= '0;
      r_door     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        PARKED: begin
          if (w_go)
            r_state <= ACCEL;
        end
        ACCEL: begin
          if (!w_go)
            r_state <= DECEL;
          if (w_tick) begin
            r_speed <= w_acc_speed;
            r_valid <= 1'b1;
          end
        end
        DECEL: begin
          if (w_go)
            r_state <= ACCEL;
          else if (r_speed == 8'd0)
            r_state <= PARKED;
          if (w_tick) begin
            r_speed <= w_dec_speed;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= PARKED;
        end
      endcase

      if (r_state != PARKED)
        r_park_cnt <= '0;
      else if (w_tick && (r_park_cnt != PW'(DOOR_HOLD)))
        r_park_cnt <= r_park_cnt + PW'(1);

      if (w_door_clr)
        r_door <= 1'b0;
      else if (w_door_set)
        r_door <= 1'b1;
    end
  end

  assign bus.car_speed     = r_speed;
  assign bus.speed_valid   = r_valid;
  assign bus.moving        = (r_speed != 8'd0);
  assign bus.door_unlocked = r_door;

endmodule

// File: tb/tb_speed_actuator.sv
// Directed bench for speed_actuator: vector table for the main
// drive/brake/door scenario plus hand-written corner sequences.
module tb_speed_actuator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  speed_actuator_if u_if ();

  speed_actuator dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    logic       acc;
    logic       unl;
    logic       brk;
    int         ncyc;
    logic [7:0] spd;
    logic       vld;
    logic       mov;
    logic       door;
    string      name;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic [7:0] spd,
                         input logic vld,
                         input logic mov,
                         input logic door);
    chk({nm, ".speed"}, 32'(u_if.car_speed), 32'(spd));
    chk({nm, ".valid"}, 32'(u_if.speed_valid), 32'(vld));
    chk({nm, ".moving"}, 32'(u_if.moving), 32'(mov));
    chk({nm, ".door"}, 32'(u_if.door_unlocked), 32'(door));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic u, input logic b);
    u_if.accelerate_car = a;
    u_if.unlock_doors   = u;
    u_if.brake_override = b;
  endtask

  task automatic do_reset(input logic a, input logic u, input logic b);
    drive(a, u, b);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  3, 8'd0,  1'b0, 1'b0, 1'b0, "pre_tick"};
    tbl[1]  = '{1'b1, 1'b0, 1'b0,  1, 8'd2,  1'b1, 1'b1, 1'b0, "tick1"};
    tbl[2]  = '{1'b1, 1'b0, 1'b0,  1, 8'd2,  1'b0, 1'b1, 1'b0, "tick1_gap"};
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  3, 8'd4,  1'b1, 1'b1, 1'b0, "tick2"};
    tbl[4]  = '{1'b1, 1'b0, 1'b0,  4, 8'd6,  1'b1, 1'b1, 1'b0, "tick3"};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 28, 8'd20, 1'b1, 1'b1, 1'b0, "to_20"};
    tbl[6]  = '{1'b1, 1'b0, 1'b1,  4, 8'd14, 1'b1, 1'b1, 1'b0, "brake1"};
    tbl[7]  = '{1'b1, 1'b0, 1'b1,  4, 8'd8,  1'b1, 1'b1, 1'b0, "brake2"};
    tbl[8]  = '{1'b1, 1'b0, 1'b1,  4, 8'd2,  1'b1, 1'b1, 1'b0, "brake3"};
    tbl[9]  = '{1'b1, 1'b0, 1'b1,  4, 8'd0,  1'b1, 1'b0, 1'b0, "brake_floor"};
    tbl[10] = '{1'b1, 1'b0, 1'b1,  4, 8'd0,  1'b0, 1'b0, 1'b0, "brake_parked"};
    tbl[11] = '{1'b0, 1'b1, 1'b0,  8, 8'd0,  1'b0, 1'b0, 1'b0, "door_wait"};
    tbl[12] = '{1'b0, 1'b1, 1'b0,  1, 8'd0,  1'b0, 1'b0, 1'b1, "door_set"};
    tbl[13] = '{1'b1, 1'b1, 1'b0,  1, 8'd0,  1'b0, 1'b0, 1'b0, "door_clr_go"};
    tbl[14] = '{1'b1, 1'b1, 1'b0,  2, 8'd2,  1'b1, 1'b1, 1'b0, "reaccel"};

    // reset state
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // main scenario: ramp, brake to park, door interlock
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].acc, tbl[i].unl, tbl[i].brk);
      step(tbl[i].ncyc);
      chk_out(tbl[i].name, tbl[i].spd, tbl[i].vld,
              tbl[i].mov, tbl[i].door);
    end

    // saturation at MAX_SPEED with continuing update pulses
    do_reset(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 102; k++) begin
      step(4);
      chk($sformatf("sat_k%0d.speed", k), 32'(u_if.car_speed),
          (2 * k > 200) ? 32'd200 : 32'(2 * k));
      chk($sformatf("sat_k%0d.valid", k), 32'(u_if.speed_valid), 32'd1);
    end
    step(1);
    chk("sat_gap.valid", 32'(u_if.speed_valid), 32'd0);

    // decel floor 10 -> 7, 4, 1, 0 then park
    do_reset(1'b1, 1'b0, 1'b0);
    step(20);
    chk("dec_start.speed", 32'(u_if.car_speed), 32'd10);
    drive(1'b0, 1'b0, 1'b0);
    begin
      logic [7:0] exp_dec [4];
      exp_dec[0] = 8'd7;
      exp_dec[1] = 8'd4;
      exp_dec[2] = 8'd1;
      exp_dec[3] = 8'd0;
      for (int j = 0; j < 4; j++) begin
        step(4);
        chk_out($sformatf("dec%0d", j), exp_dec[j], 1'b1,
                exp_dec[j] != 8'd0, 1'b0);
      end
    end
    step(4);
    chk_out("dec_parked", 8'd0, 1'b0, 1'b0, 1'b0);

    // door: hold time, unlock drop, relock, async reset clear
    do_reset(1'b0, 1'b1, 1'b0);
    step(12);
    chk("door_early", 32'(u_if.door_unlocked), 32'd0);
    step(1);
    chk("door_on", 32'(u_if.door_unlocked), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    step(1);
    chk("door_unl_drop", 32'(u_if.door_unlocked), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    step(1);
    chk("door_relock", 32'(u_if.door_unlocked), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("door_async_rst", 32'(u_if.door_unlocked), 32'd0);
    rst = 1'b0;

    // reset mid-motion at speed 50, then first tick timing
    do_reset(1'b1, 1'b0, 1'b0);
    step(100);
    chk("pre_rst.speed", 32'(u_if.car_speed), 32'd50);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(3);
    chk_out("post_rst_e3", 8'd0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("post_rst_e4", 8'd2, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_actuator.md
SPEED_ACTUATOR -- requirements
Module: speed_actuator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- TICK_DIV, 4: clocks per speed-update tick.
- ACC_STEP, 8'd2: speed increment per tick.
- DEC_STEP, 8'd3: speed decrement per tick.
- MAX_SPEED, 8'd200: saturation ceiling.
- DOOR_HOLD, 3: consecutive stationary ticks required before doors unlock.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- accelerate_car, input, 1: acceleration request from the driving-control FSM.
- unlock_doors, input, 1: door-unlock request from the driving-control FSM.
- brake_override, input, 1: emergency brake.
- car_speed, output, 8: current modelled speed, registered; fed back to the driving-control FSM.
- speed_valid, output, 1: one-cycle pulse on each speed update.
- moving, output, 1: high when car_speed != 0.
- door_unlocked, output, 1: registered door latch state.
REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-004 A free-running tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick = (count == TICK_DIV-1).
REQ-005 The state machine SHALL have three states, PARKED=2'b00, ACCEL=2'b01 and DECEL=2'b10; any other encoding SHALL go to PARKED on the next clock.
REQ-006 State transitions SHALL be evaluated every clock, not only on tick.
- PARKED -> ACCEL when accelerate_car=1 and brake_override=0.
- ACCEL -> DECEL when accelerate_car=0 or brake_override=1.
- DECEL -> ACCEL when accelerate_car=1 and brake_override=0.
- DECEL -> PARKED when car_speed==0 and the ACCEL condition is false.
- Otherwise the state SHALL hold.
REQ-007 Speed SHALL change only on tick cycles, using the current (registered) state:
- ACCEL: car_speed <= min(car_speed+ACC_STEP, MAX_SPEED), computed at 9 bits with no 8-bit wrap.
- DECEL: car_speed <= car_speed-DEC_STEP, floored at 0.
- PARKED: car_speed holds.
REQ-008 While brake_override=1, DECEL updates SHALL use step 2*DEC_STEP, floored at 0.
REQ-009 speed_valid SHALL be high for exactly the one clock after each tick edge on which car_speed was written.
- This includes writes that leave the value unchanged (saturated at MAX_SPEED or floored at 0).
- It excludes PARKED.
REQ-010 moving SHALL be combinational from car_speed (car_speed != 0).
REQ-011 A park counter (saturating at DOOR_HOLD) SHALL behave as follows:
- Increment on each tick while the state is PARKED.
- Clear whenever the state is not PARKED.
REQ-012 door_unlocked SHALL set on the clock where state==PARKED, unlock_doors=1 and the park counter == DOOR_HOLD.
REQ-013 door_unlocked SHALL clear on the next clock when unlock_doors=0, accelerate_car=1, or the state leaves PARKED. Clear SHALL take priority over set.
REQ-014 accelerate_car=1 while door_unlocked=1 SHALL first clear door_unlocked; the PARKED->ACCEL transition SHALL still occur on that same clock.

Reset
REQ-015 On rst=1 the following SHALL reset immediately, regardless of clk:
- state=PARKED, tick counter=0, park counter=0.
- car_speed=0, speed_valid=0, door_unlocked=0, moving=0.
REQ-016 Reset asserted mid-motion SHALL discard speed and state. After release, the first tick SHALL occur on the TICK_DIV-th rising clk edge.

Verification
REQ-017 Accelerate ramp: release reset, hold accelerate_car=1 -> car_speed 2, 4, 6 at ticks 1, 2, 3 (every 4 clocks), with speed_valid pulsing once per tick.
REQ-018 Saturation: accelerate from 198 -> car_speed 200 and stays 200; speed_valid still pulses each tick.
REQ-019 Decel floor and park: car_speed=7, accelerate_car=0 -> speeds 4, 1, 0, then state PARKED; moving falls with car_speed=0.
REQ-020 Brake override: car_speed=20, accelerate_car=1, brake_override=1 -> speeds 14, 8, 2, 0; ACCEL never entered.
REQ-021 Door interlock: in PARKED with unlock_doors=1 -> door_unlocked rises after the 3rd parked tick. Then accelerate_car=1 -> door_unlocked=0 on the next clock, and state ACCEL.
REQ-022 Reset mid-operation: car_speed=50 in ACCEL, pulse rst between clocks -> car_speed=0 and door_unlocked=0 immediately, state PARKED.
